xor_end_stage: RTL and testbench

//  Registered, mode-selectable XOR stage that sits after the ASCON permutation
//  (ascon_pack type_state) and generalises the combinational end-XOR.
//  - Modes: init-end key XOR, domain separation, finalization key XOR with
//    tag extraction and tag compare, plain pass-through.
//  - Key width is parametrised (128 or 160 bit).
//  - One-entry pipeline register with valid/ready handshake on both sides.

---
 rtl/xor_end_stage.sv | 108 ++++++++++
 tb/tb_xor_end_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/xor_end_stage.sv
`default_nettype none
// ============================================================================
//  Module      : xor_end_stage
//  Description : Registered, mode-selectable XOR stage placed after the ASCON
//                permutation (init-end key XOR, domain separation, final key
//                XOR with tag extraction/compare, pass-through).
//  Revision    : 1.0 - initial release
// ============================================================================
module xor_end_stage #(
    parameter int          KEY_W     = 128,
    parameter logic [63:0] DSEP_MASK = 64'h0000000000000001
) (
    input  logic                 clock_i,
    input  logic                 resetb_i,
    // upstream side
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [1:0]           mode_i,
    input  logic [4:0][63:0]     state_i,
    input  logic [KEY_W-1:0]     key_i,
    input  logic [127:0]         tag_ref_i,
    // downstream side
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [4:0][63:0]     state_o,
    output logic [127:0]         tag_o,
    output logic                 tag_match_o
);

    localparam logic [1:0] c_MODE_PASS     = 2'b00;
    localparam logic [1:0] c_MODE_INIT_END = 2'b01;
    localparam logic [1:0] c_MODE_DSEP     = 2'b10;
    localparam logic [1:0] c_MODE_FINAL    = 2'b11;

    logic [4:0][63:0] w_key_mask;
    logic [4:0][63:0] w_state_nxt;
    logic [127:0]     w_tag_nxt;
    logic             w_match_nxt;
    logic             w_accept;

    logic             r_valid;
    logic [4:0][63:0] r_state;
    logic [127:0]     r_tag;
    logic             r_tag_match;

    // Key words line up with the tail of the state: {w4, w3, w2, w1, w0}.
    if (KEY_W == 128) begin : g_key128
        assign w_key_mask = {key_i[63:0], key_i[127:64], 64'h0, 64'h0, 64'h0};
    end else if (KEY_W == 160) begin : g_key160
        assign w_key_mask = {key_i[63:0], key_i[127:64],
                             {32'h0, key_i[159:128]}, 64'h0, 64'h0};
    end else begin : g_key_bad
        $error("xor_end_stage: KEY_W must be 128 or 160");
        assign w_key_mask = '0;
    end

    assign ready_o  = !r_valid || ready_i;
    assign w_accept = valid_i && ready_o;

    always_comb begin
        w_state_nxt = state_i;
        w_tag_nxt   = '0;
        w_match_nxt = 1'b0;
        case (mode_i)
            c_MODE_PASS: begin
                w_state_nxt = state_i;
            end
            c_MODE_INIT_END: begin
                w_state_nxt = state_i ^ w_key_mask;
            end
            c_MODE_DSEP: begin
                w_state_nxt[4] = state_i[4] ^ DSEP_MASK;
            end
            c_MODE_FINAL: begin
                w_state_nxt = state_i ^ w_key_mask;
                w_tag_nxt   = {w_state_nxt[3], w_state_nxt[4]};
                w_match_nxt = (w_tag_nxt == tag_ref_i);
            end
            default: begin
                w_state_nxt = state_i;
            end
        endcase
    end

    // Accept has priority: a simultaneous consume+accept simply replaces data.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_valid     <= 1'b0;
            r_state     <= '0;
            r_tag       <= '0;
            r_tag_match <= 1'b0;
        end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_state     <= w_state_nxt;
            r_tag       <= w_tag_nxt;
            r_tag_match <= w_match_nxt;
        end else if (ready_i) begin
            r_valid     <= 1'b0;
        end
    end

    assign valid_o     = r_valid;
    assign state_o     = r_state;
    assign tag_o       = r_tag;
    assign tag_match_o = r_tag_match;

endmodule
`default_nettype wire

// File: tb/tb_xor_end_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xor_end_stage
//  Description : Self-checking bench for xor_end_stage (KEY_W 128 and 160).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xor_end_stage;

    localparam logic [63:0]  c_S3  = 64'h4dd2c87c59c2fb48;
    localparam logic [63:0]  c_S4  = 64'h4e2b20c3e9eb3044;
    localparam logic [127:0] c_KEY = 128'h691AED630E81901F6CB10AD9CA912F80;
    localparam logic [127:0] c_TAG = 128'h24c8251f57436b57229a2a1a237a1fc4;

    typedef struct packed {
        logic [4:0][63:0] st;
        logic [127:0]     tag;
        logic             match;
    } res_t;

    logic             clk;
    logic             rst_n;
    logic             valid;
    logic [1:0]       mode;
    logic [4:0][63:0] st;
    logic [159:0]     key160;
    logic [127:0]     tref;
    logic             rdy;

    logic             a_ready, a_valid, a_match;
    logic [4:0][63:0] a_state;
    logic [127:0]     a_tag;
    logic             b_ready, b_valid, b_match;
    logic [4:0][63:0] b_state;
    logic [127:0]     b_tag;

    int n_checks = 0;
    int n_fail   = 0;

    res_t q128[$];
    res_t q160[$];

    xor_end_stage #(.KEY_W(128)) dut128 (
        .clock_i(clk), .resetb_i(rst_n), .valid_i(valid), .ready_o(a_ready),
        .mode_i(mode), .state_i(st), .key_i(key160[127:0]), .tag_ref_i(tref),
        .valid_o(a_valid), .ready_i(rdy), .state_o(a_state), .tag_o(a_tag),
        .tag_match_o(a_match)
    );

    xor_end_stage #(.KEY_W(160)) dut160 (
        .clock_i(clk), .resetb_i(rst_n), .valid_i(valid), .ready_o(b_ready),
        .mode_i(mode), .state_i(st), .key_i(key160), .tag_ref_i(tref),
        .valid_o(b_valid), .ready_i(rdy), .state_o(b_state), .tag_o(b_tag),
        .tag_match_o(b_match)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected result of one transfer, straight from the mode/key rules.
    function automatic res_t model(input logic [1:0] m, input logic [4:0][63:0] s,
                                   input logic [159:0] k, input int kw,
                                   input logic [127:0] tr);
        res_t r;
        r.st    = s;
        r.tag   = '0;
        r.match = 1'b0;
        if (m == 2'd1 || m == 2'd3) begin
            r.st[3] = s[3] ^ k[127:64];
            r.st[4] = s[4] ^ k[63:0];
            if (kw == 160) r.st[2] = s[2] ^ {32'h0, k[159:128]};
        end
        if (m == 2'd2) r.st[4] = s[4] ^ 64'h1;
        if (m == 2'd3) begin
            r.tag   = {r.st[3], r.st[4]};
            r.match = (r.tag == tr);
        end
        return r;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Transaction-level model: one-deep queue per DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q128.delete();
            q160.delete();
        end else begin
            if (valid && (q128.size() == 0 || rdy)) begin
                if (q128.size() != 0) q128.delete(0);
                q128.push_back(model(mode, st, key160, 128, tref));
            end else if (rdy && q128.size() != 0) begin
                q128.delete(0);
            end
            if (valid && (q160.size() == 0 || rdy)) begin
                if (q160.size() != 0) q160.delete(0);
                q160.push_back(model(mode, st, key160, 160, tref));
            end else if (rdy && q160.size() != 0) begin
                q160.delete(0);
            end
        end
    end

    task automatic cmp(input string p, input logic v, input logic r, input logic [319:0] s,
                       input logic [127:0] t, input logic m, input logic ev, input res_t e);
        chk({p, "_valid_o"}, {319'h0, v}, {319'h0, ev});
        chk({p, "_ready_o"}, {319'h0, r}, {319'h0, (!ev || rdy)});
        if (ev) begin
            chk({p, "_state_o"}, s, e.st);
            chk({p, "_tag_o"}, {192'h0, t}, {192'h0, e.tag});
            chk({p, "_tag_match_o"}, {319'h0, m}, {319'h0, e.match});
        end else if (!rst_n) begin
            chk({p, "_rst_out"}, {s[255:0] ^ {128'h0, t}, 63'h0, m}, 320'h0);
        end
    endtask

    always @(negedge clk) begin
        cmp("d128", a_valid, a_ready, a_state, a_tag, a_match,
            q128.size() != 0, (q128.size() != 0) ? q128[0] : '0);
        cmp("d160", b_valid, b_ready, b_state, b_tag, b_match,
            q160.size() != 0, (q160.size() != 0) ? q160[0] : '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0][63:0] p [3];
    logic [4:0][63:0] d;

    initial begin
        rst_n = 1'b0; valid = 1'b0; mode = 2'd0; st = '0;
        key160 = '0; tref = '0; rdy = 1'b1;
        #12;
        chk("rst_valid", {319'h0, a_valid}, 320'h0);
        chk("rst_ready", {319'h0, a_ready}, 320'h1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // FINAL with matching reference tag
        st = '0; st[3] = c_S3; st[4] = c_S4;
        key160 = {32'h01234567, c_KEY}; mode = 2'd3; tref = c_TAG; valid = 1'b1; rdy = 1'b1;
        tick();
        chk("t1_valid", {319'h0, a_valid}, 320'h1);
        chk("t1_state3", {256'h0, a_state[3]}, {256'h0, 64'h24c8251f57436b57});
        chk("t1_state4", {256'h0, a_state[4]}, {256'h0, 64'h229a2a1a237a1fc4});
        chk("t1_tag", {192'h0, a_tag}, {192'h0, c_TAG});
        chk("t2_match", {319'h0, a_match}, 320'h1);
        tref = c_TAG ^ 128'h1;
        tick();
        chk("t2_nomatch", {319'h0, a_match}, 320'h0);
        chk("t2_tag", {192'h0, a_tag}, {192'h0, c_TAG});

        // Backpressure: a new item waits while the result holds
        for (int i = 0; i < 3; i++) p[i] = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
        rdy = 1'b0; mode = 2'd0; st = p[0];
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_hold_valid", {319'h0, a_valid}, 320'h1);
            chk("t4_hold_ready", {319'h0, a_ready}, 320'h0);
            chk("t4_hold_tag", {192'h0, a_tag}, {192'h0, c_TAG});
        end
        rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            st = p[i];
            tick();
            chk("t4_stream_state", a_state, p[i]);
            chk("t4_stream_valid", {319'h0, a_valid}, 320'h1);
        end

        // Domain separation
        mode = 2'd2;
        d = {c_S4, rnd64(), rnd64(), rnd64(), rnd64()};
        st = d;
        tick();
        chk("t3_state4", {256'h0, a_state[4]}, {256'h0, 64'h4e2b20c3e9eb3045});
        chk("t3_words", {64'h0, a_state[3:0]}, {64'h0, d[3:0]});
        chk("t3_tag", {192'h0, a_tag}, 320'h0);

        // 160-bit key reaches word 2
        mode = 2'd1;
        st = {rnd64(), rnd64(), 64'h0, rnd64(), rnd64()};
        key160 = {32'hDEADBEEF, c_KEY};
        tick();
        chk("t6_state2", {256'h0, b_state[2]}, {256'h0, 64'h00000000DEADBEEF});
        chk("t6_state2_k128", {256'h0, a_state[2]}, 320'h0);

        // Asynchronous reset while holding
        mode = 2'd3; st[3] = c_S3; st[4] = c_S4; key160 = {32'h0, c_KEY};
        tick();
        valid = 1'b0; rdy = 1'b0;
        tick();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid", {318'h0, a_valid, b_valid}, 320'h0);
        chk("t5_state", a_state | b_state, 320'h0);
        chk("t5_tag", {192'h0, a_tag | b_tag}, 320'h0);
        chk("t5_match", {318'h0, a_match, b_match}, 320'h0);
        chk("t5_ready", {318'h0, a_ready, b_ready}, 320'h3);
        tick();
        chk("t5_held", {a_state[4:1], 63'h0, a_valid}, 320'h0);
        #2 rst_n = 1'b1;
        tick();
        chk("t5_ready_after", {319'h0, a_ready}, 320'h1);
        chk("t5_valid_after", {319'h0, a_valid}, 320'h0);

        // Randomized traffic checked by the model
        for (int i = 0; i < 400; i++) begin
            valid  = ($urandom_range(0, 3) != 0);
            mode   = 2'($urandom_range(0, 3));
            st     = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
            key160 = {$urandom, rnd64(), rnd64()};
            tref   = {rnd64(), rnd64()};
            if ($urandom_range(0, 1) == 1) tref = model(2'd3, st, key160, 128, 128'h0).tag;
            rdy    = ($urandom_range(0, 3) != 0);
            tick();
        end
        valid = 1'b0; rdy = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
